// File: rtl/bus_hold_arbiter.sv
// bus_hold_arbiter: round-robin HOLD/HLDA arbiter for the 8088 local bus.
// The bus is handed back to the CPU between every two requester grants.
module bus_hold_arbiter #(
    parameter int NREQ       = 4,
    parameter int MAX_TENURE = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [NREQ-1:0]         DREQ,
    input  logic                    HLDA,
    output logic                    HOLD,
    output logic [NREQ-1:0]         DACK,
    output logic [$clog2(NREQ)-1:0] OWNER,
    output logic                    PREEMPT,
    output logic                    ERR
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_TENURE + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GRANT,
        DROP,
        WAITLO,
        GAP
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   rr_n;
    logic [IW-1:0]   owner_n;
    logic [IW-1:0]   win;
    logic            win_vld;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [GW-1:0]   gcnt;
    logic [GW-1:0]   gcnt_n;
    logic            hold_n;
    logic            preempt_n;
    logic            err_n;
    logic [NREQ-1:0] dack_n;

    // b is always below NREQ, so one conditional subtract wraps it
    function automatic logic [IW-1:0] wrap_add(
        input logic [IW-1:0] a,
        input int            b
    );
        int s;
        s = int'(a) + b;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IW'(s);
    endfunction

    // Scan downward so the last hit is the nearest bit at or above rr
    always_comb begin
        win     = rr;
        win_vld = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (DREQ[wrap_add(rr, i)]) begin
                win     = wrap_add(rr, i);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        hold_n    = HOLD;
        dack_n    = DACK;
        owner_n   = OWNER;
        rr_n      = rr;
        cnt_n     = cnt;
        gcnt_n    = gcnt;
        preempt_n = 1'b0;
        err_n     = ERR;
        unique case (state)
            IDLE: begin
                if (|DREQ) begin
                    hold_n  = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (HLDA) begin
                    if (win_vld) begin
                        dack_n  = NREQ'(1) << win;
                        owner_n = win;
                        cnt_n   = CW'(1);
                        state_n = GRANT;
                    end else begin
                        state_n = DROP;
                    end
                end
            end
            GRANT: begin
                // Losing HLDA mid-grant outranks release and expiry
                if (!HLDA) begin
                    dack_n  = '0;
                    err_n   = 1'b1;
                    hold_n  = 1'b0;
                    rr_n    = wrap_add(OWNER, 1);
                    state_n = WAITLO;
                end else if (!DREQ[OWNER]) begin
                    dack_n  = '0;
                    rr_n    = wrap_add(OWNER, 1);
                    state_n = DROP;
                end else if (cnt == CW'(MAX_TENURE)) begin
                    dack_n    = '0;
                    preempt_n = 1'b1;
                    rr_n      = wrap_add(OWNER, 1);
                    state_n   = DROP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DROP: begin
                hold_n  = 1'b0;
                state_n = WAITLO;
            end
            WAITLO: begin
                if (!HLDA) begin
                    if (GAP_CYCLES == 0) begin
                        state_n = IDLE;
                    end else begin
                        gcnt_n  = GW'(GAP_CYCLES);
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                if (gcnt <= GW'(1)) begin
                    state_n = IDLE;
                end else begin
                    gcnt_n = gcnt - GW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state   <= IDLE;
            HOLD    <= 1'b0;
            DACK    <= '0;
            OWNER   <= '0;
            PREEMPT <= 1'b0;
            ERR     <= 1'b0;
            rr      <= '0;
            cnt     <= '0;
            gcnt    <= '0;
        end else begin
            state   <= state_n;
            HOLD    <= hold_n;
            DACK    <= dack_n;
            OWNER   <= owner_n;
            PREEMPT <= preempt_n;
            ERR     <= err_n;
            rr      <= rr_n;
            cnt     <= cnt_n;
            gcnt    <= gcnt_n;
        end
    end

    a_onehot: assert property (
        @(posedge CLK) disable iff (!RESET_N)
        $onehot0(DACK)
    );

    a_dack_hold: assert property (
        @(posedge CLK) disable iff (!RESET_N)
        (DACK != '0) |-> (HOLD && state == GRANT)
    );

endmodule
